hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the ID/EX stage register and the upstream IF/ID stages. It detects RAW hazards between the decode-stage sources and the EXE/MEM destinations, and counts multi-cycle data-memory waits. It produces the stall, superStall and flush controls consumed by the ID/EX register, plus a freeze for PC and IF/ID. It also keeps a saturating stall-cycle statistic for debug.

---
 rtl/hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the ID/EX stage register and the
//            upstream PC / IF/ID stages.
//            - Detects RAW hazards between the decode sources and the EXE/MEM
//              destinations and raises stall.
//            - Sequences multi-cycle data-memory accesses and raises
//              superStall while a wait is in progress.
//            - Squashes the front end with flush on a taken branch.
//            - Keeps a saturating count of frozen cycles for debug.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   FORWARDING_EN  defined   : only load-use hazards against EXE stall.
//                  undefined : any pending EXE or MEM writer stalls.
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_LATENCY  total data-memory access cycles per request (1..255)
//   CNT_W        width of the stall-cycle statistic counter
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-low reset
//   id_valid      in   decode stage holds a real instruction
//   id_src1       in   decode source register 1
//   id_src2       in   decode source register 2
//   id_src2_used  in   src2 is actually read
//   exe_dest      in   EXE-stage destination register
//   exe_WB_En     in   EXE-stage instruction writes back
//   exe_MEM_R_En  in   EXE-stage instruction is a load
//   mem_dest      in   MEM-stage destination register
//   mem_WB_En     in   MEM-stage instruction writes back
//   mem_req       in   MEM stage starts a data-memory access this cycle
//   branch_taken  in   EXE resolved a taken branch
//   stall         out  hold ID/EX, PC and IF/ID for a data hazard
//   superStall    out  hold the whole front end during a memory wait
//   flush         out  squash IF/ID and ID/EX contents
//   freeze_front  out  stall | superStall (PC and IF/ID enable)
//   mem_busy      out  FSM is in WAIT
//   stall_cycles  out  saturating count of cycles with freeze_front=1
// ============================================================================
module hazard_ctrl #(
   parameter int MEM_LATENCY = 6,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic             id_src2_used,
   input  logic [4:0]       exe_dest,
   input  logic             exe_WB_En,
   input  logic             exe_MEM_R_En,
   input  logic [4:0]       mem_dest,
   input  logic             mem_WB_En,
   input  logic             mem_req,
   input  logic             branch_taken,
   output logic             stall,
   output logic             superStall,
   output logic             flush,
   output logic             freeze_front,
   output logic             mem_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // The request cycle itself is held whenever the access takes more than one
   // cycle; the final access cycle is never held. That leaves MEM_LATENCY-2
   // cycles to be covered by WAIT.
   localparam bit         C_HOLD_REQ  = (MEM_LATENCY > 1);
   localparam bit         C_USE_WAIT  = (MEM_LATENCY > 2);
   localparam logic [7:0] C_WAIT_LOAD = C_USE_WAIT ? 8'(MEM_LATENCY - 2) : 8'd0;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;          // WAIT cycles still to be spent
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   // -------------------------------------------------------------------------
   // Combinational wires
   // -------------------------------------------------------------------------
   logic w_src1_live;
   logic w_src2_live;
   logic w_exe_hit;
   logic w_mem_hit;
   logic w_hazard;
   logic w_super_raw;
   logic w_flush_raw;
   logic w_stall_raw;

   // Register 0 is hard-wired, so it never carries a dependency.
   function automatic logic match(input logic [4:0] r, input logic [4:0] d);
      return (r == d) && (d != 5'd0);
   endfunction

   // -------------------------------------------------------------------------
   // RAW hazard detection
   // -------------------------------------------------------------------------
   always_comb begin
      w_src1_live = id_valid;
      w_src2_live = id_valid & id_src2_used;

      w_exe_hit = (w_src1_live & match(id_src1, exe_dest)) |
                  (w_src2_live & match(id_src2, exe_dest));
      w_mem_hit = (w_src1_live & match(id_src1, mem_dest)) |
                  (w_src2_live & match(id_src2, mem_dest));

`ifdef FORWARDING_EN
      // Results from EXE and MEM are forwarded; only a load in EXE cannot
      // supply its data in time for the dependent instruction.
      w_hazard = exe_MEM_R_En & exe_WB_En & w_exe_hit;
`else
      // No bypass network: any writer still in flight must retire first.
      w_hazard = (exe_WB_En & w_exe_hit) | (mem_WB_En & w_mem_hit);
`endif
   end

   // -------------------------------------------------------------------------
   // Memory-wait FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (mem_req && C_USE_WAIT) begin
               state_d = WAIT;
               cnt_d   = C_WAIT_LOAD;
            end
         end
         WAIT: begin
            // mem_req is ignored here; the in-flight access owns the port.
            if (cnt_q <= 8'd1) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control outputs. Priority: superStall > flush > stall, so at most one is
   // ever high. A branch seen during a wait stays parked in EXE and its flush
   // fires on the first cycle the wait releases.
   // -------------------------------------------------------------------------
   always_comb begin
      w_super_raw = ((state_q == IDLE) & mem_req & C_HOLD_REQ) |
                    (state_q == WAIT);
      w_flush_raw = branch_taken & ~w_super_raw;
      w_stall_raw = w_hazard & ~w_flush_raw & ~w_super_raw;

      // Everything is held quiet while reset is asserted.
      superStall   = rst & w_super_raw;
      flush        = rst & w_flush_raw;
      stall        = rst & w_stall_raw;
      freeze_front = stall | superStall;
      mem_busy     = rst & (state_q == WAIT);
   end

   // -------------------------------------------------------------------------
   // Stall-cycle statistic (saturating)
   // -------------------------------------------------------------------------
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (freeze_front && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cycles = stall_cycles_q;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= 8'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Three instances share the
//            same stimulus: the default configuration, a CNT_W=4 copy for
//            counter saturation and a MEM_LATENCY=1 copy for the single-cycle
//            memory boundary.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_src1;
   logic [4:0] id_src2;
   logic       id_src2_used;
   logic [4:0] exe_dest;
   logic       exe_WB_En;
   logic       exe_MEM_R_En;
   logic [4:0] mem_dest;
   logic       mem_WB_En;
   logic       mem_req;
   logic       branch_taken;

   logic        stall, super_stall, flush, freeze_front, mem_busy;
   logic [15:0] stall_cycles;
   logic        s_stall, s_super, s_flush, s_freeze, s_busy;
   logic [3:0]  s_cycles;
   logic        l_stall, l_super, l_flush, l_freeze, l_busy;
   logic [15:0] l_cycles;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MEM_LATENCY(6), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .exe_dest(exe_dest),
      .exe_WB_En(exe_WB_En), .exe_MEM_R_En(exe_MEM_R_En), .mem_dest(mem_dest),
      .mem_WB_En(mem_WB_En), .mem_req(mem_req), .branch_taken(branch_taken),
      .stall(stall), .superStall(super_stall), .flush(flush),
      .freeze_front(freeze_front), .mem_busy(mem_busy),
      .stall_cycles(stall_cycles)
   );

   hazard_ctrl #(.MEM_LATENCY(6), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .exe_dest(exe_dest),
      .exe_WB_En(exe_WB_En), .exe_MEM_R_En(exe_MEM_R_En), .mem_dest(mem_dest),
      .mem_WB_En(mem_WB_En), .mem_req(mem_req), .branch_taken(branch_taken),
      .stall(s_stall), .superStall(s_super), .flush(s_flush),
      .freeze_front(s_freeze), .mem_busy(s_busy), .stall_cycles(s_cycles)
   );

   hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) dut_l1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .exe_dest(exe_dest),
      .exe_WB_En(exe_WB_En), .exe_MEM_R_En(exe_MEM_R_En), .mem_dest(mem_dest),
      .mem_WB_En(mem_WB_En), .mem_req(mem_req), .branch_taken(branch_taken),
      .stall(l_stall), .superStall(l_super), .flush(l_flush),
      .freeze_front(l_freeze), .mem_busy(l_busy), .stall_cycles(l_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [4:0] src1;
      logic [4:0] src2;
      logic       used;
      logic [4:0] exe_dest;
      logic       exe_wb;
      logic       exe_mr;
      logic [4:0] mem_dest;
      logic       mem_wb;
      logic       br;
      logic       st_fwd;   // expected stall with forwarding
      logic       st_nf;    // expected stall without forwarding
      logic       fl;       // expected flush
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #3;
   endtask

   task automatic clear_inputs();
      id_valid     = 1'b0;
      id_src1      = 5'd0;
      id_src2      = 5'd0;
      id_src2_used = 1'b0;
      exe_dest     = 5'd0;
      exe_WB_En    = 1'b0;
      exe_MEM_R_En = 1'b0;
      mem_dest     = 5'd0;
      mem_WB_En    = 1'b0;
      mem_req      = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Load in EXE writing r5, decode reads r5: a hazard in either build.
   task automatic set_load_use();
      id_valid     = 1'b1;
      id_src1      = 5'd5;
      exe_dest     = 5'd5;
      exe_WB_En    = 1'b1;
      exe_MEM_R_En = 1'b1;
   endtask

   logic exp_st;
   logic exp_ss[6];
   logic exp_bz[6];

   initial begin
      // valid src1 src2 used exe_d wb mr mem_d mwb br  fwd nf fl
      vecs[0]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 5'd1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 5'd2, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // ---------------- Reset with aggressive inputs ----------------
      rst = 1'b0;
      clear_inputs();
      mem_req      = 1'b1;
      branch_taken = 1'b1;
      set_load_use();
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("rst_stall",    {31'd0, stall},        32'd0);
         chk("rst_super",    {31'd0, super_stall},  32'd0);
         chk("rst_flush",    {31'd0, flush},        32'd0);
         chk("rst_freeze",   {31'd0, freeze_front}, 32'd0);
         chk("rst_busy",     {31'd0, mem_busy},     32'd0);
         chk("rst_cycles",   {16'd0, stall_cycles}, 32'd0);
      end
      clear_inputs();
      tick();
      rst = 1'b1;

      // ---------------- Combinational hazard / flush table ----------------
      for (int i = 0; i < 13; i++) begin
         id_valid     = vecs[i].valid;
         id_src1      = vecs[i].src1;
         id_src2      = vecs[i].src2;
         id_src2_used = vecs[i].used;
         exe_dest     = vecs[i].exe_dest;
         exe_WB_En    = vecs[i].exe_wb;
         exe_MEM_R_En = vecs[i].exe_mr;
         mem_dest     = vecs[i].mem_dest;
         mem_WB_En    = vecs[i].mem_wb;
         mem_req      = 1'b0;
         branch_taken = vecs[i].br;
`ifdef FORWARDING_EN
         exp_st = vecs[i].st_fwd;
`else
         exp_st = vecs[i].st_nf;
`endif
         settle();
         chk($sformatf("vec%0d_stall", i),  {31'd0, stall},        {31'd0, exp_st});
         chk($sformatf("vec%0d_flush", i),  {31'd0, flush},        {31'd0, vecs[i].fl});
         chk($sformatf("vec%0d_super", i),  {31'd0, super_stall},  32'd0);
         chk($sformatf("vec%0d_freeze", i), {31'd0, freeze_front}, {31'd0, exp_st});
         tick();
      end

      // ---------------- Memory wait, MEM_LATENCY=6 ----------------
      do_reset();
      exp_ss = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 6; c++) begin
         // Request at cycle 0; a second request at cycle 2 must be ignored.
         mem_req = (c == 0) || (c == 2);
         settle();
         chk($sformatf("wait_c%0d_super", c), {31'd0, super_stall}, {31'd0, exp_ss[c]});
         chk($sformatf("wait_c%0d_busy", c),  {31'd0, mem_busy},    {31'd0, exp_bz[c]});
         chk($sformatf("wait_c%0d_stall", c), {31'd0, stall},       32'd0);
         if (c == 0) chk("l1_super_on_req", {31'd0, l_super}, 32'd0);
         if (c == 1) chk("l1_busy_after_req", {31'd0, l_busy}, 32'd0);
         if (c == 5) chk("wait_stall_cycles", {16'd0, stall_cycles}, 32'd5);
         tick();
      end
      chk("l1_cycles_after_req", {16'd0, l_cycles}, 32'd0);

      // ---------------- Branch during a wait ----------------
      do_reset();
      set_load_use();
      for (int c = 0; c < 7; c++) begin
         mem_req      = (c == 0);
         branch_taken = (c >= 1) && (c <= 5);
         settle();
         chk($sformatf("br_c%0d_super", c), {31'd0, super_stall}, {31'd0, (c <= 4)});
         chk($sformatf("br_c%0d_flush", c), {31'd0, flush},       {31'd0, (c == 5)});
         chk($sformatf("br_c%0d_stall", c), {31'd0, stall},       {31'd0, (c == 6)});
         if (c == 6) chk("br_stall_cycles", {16'd0, stall_cycles}, 32'd5);
         tick();
      end

      // ---------------- Reset in the middle of WAIT ----------------
      do_reset();
      mem_req = 1'b1;
      tick();
      mem_req = 1'b0;
      tick();
      settle();
      chk("midwait_busy_before", {31'd0, mem_busy}, 32'd1);
      rst = 1'b0;
      settle();
      chk("midwait_super_in_rst", {31'd0, super_stall}, 32'd0);
      tick();
      rst = 1'b1;
      settle();
      chk("midwait_super_after", {31'd0, super_stall}, 32'd0);
      chk("midwait_busy_after",  {31'd0, mem_busy},    32'd0);

      // ---------------- Counter saturation ----------------
      do_reset();
      set_load_use();
      for (int c = 0; c < 20; c++) tick();
      settle();
      chk("sat_stall_held", {31'd0, s_stall},      32'd1);
      chk("sat_cnt4",       {28'd0, s_cycles},     32'd15);
      chk("sat_cnt16",      {16'd0, stall_cycles}, 32'd20);
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
